attack_ctrl: RTL

// - Sequences CY's attack: accepts an attack request, latches facing, runs WINDUP -> ACTIVE -> COOLDOWN timing.
// - Drives the CY attack state code (4'hA-4'hD) consumed by weapon and sprite logic; owns current weapon type selection.
// - Sits between input debouncers/stage FSM and the weapon/CY render blocks; single owner of the attack resource.

---
 rtl/attack_ctrl_pkg.sv | 44 ++++
 rtl/attack_ctrl_weapon_cycler.sv | 73 +++++++
 rtl/attack_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/attack_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : attack_ctrl_pkg
// Purpose  : Shared codes for the CY attack sequencer: stage codes, attack
//            state codes, weapon types and the attack phase encoding.
// Revision : 1.0 - initial release
// ============================================================================
package attack_ctrl_pkg;

   // Stage codes that mark the game as not running
   localparam logic [3:0] STG_INIT = 4'h0;
   localparam logic [3:0] STG_OVER = 4'he;
   localparam logic [3:0] STG_WIN  = 4'hf;

   // Attack state codes seen by weapon and sprite logic
   localparam logic [3:0] ATK_NONE  = 4'h0;
   localparam logic [3:0] ATK_BACK  = 4'hA;
   localparam logic [3:0] ATK_FRONT = 4'hB;
   localparam logic [3:0] ATK_LEFT  = 4'hC;
   localparam logic [3:0] ATK_RIGHT = 4'hD;

   // Weapon types
   localparam logic [2:0] WPN_WOODEN = 3'd0;
   localparam logic [2:0] WPN_BASYS  = 3'd1;
   localparam logic [2:0] WPN_CAR    = 3'd2;

   // The wooden weapon can never be locked
   localparam logic [2:0] WPN_ALWAYS_MASK = 3'b001;

   // Attack phase encoding
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WINDUP   = 2'd1,
      ST_ACTIVE   = 2'd2,
      ST_COOLDOWN = 2'd3
   } phase_e;

   // True while the game is actually being played
   function automatic logic stage_is_active(input logic [3:0] stg);
      return !((stg == STG_INIT) || (stg == STG_OVER) || (stg == STG_WIN));
   endfunction

endpackage
`default_nettype wire

// File: rtl/attack_ctrl_weapon_cycler.sv
`default_nettype none
// ============================================================================
// Module   : weapon_cycler
// Purpose  : Holds the selected weapon type. Steps to the next unlocked type
//            on request (only when enabled) and falls back to the wooden
//            weapon whenever the current type gets locked.
// Revision : 1.0 - initial release
// ============================================================================
module weapon_cycler
   import attack_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] unlocked_i,
   input  logic       wpn_next_i,
   input  logic       enable_i,
   output logic [2:0] weapon_type_o
);

   logic [2:0] wtype_q;
   logic [2:0] wtype_d;
   logic [2:0] avail_w;
   logic       cur_ok_w;
   logic [2:0] next_w;

   assign avail_w = unlocked_i | WPN_ALWAYS_MASK;

   // Availability of the current type and the next set bit above it (wraps to wooden)
   always_comb begin
      cur_ok_w = 1'b0;
      next_w   = WPN_WOODEN;
      case (wtype_q)
         WPN_WOODEN: begin
            cur_ok_w = 1'b1;
            if (avail_w[1])      next_w = WPN_BASYS;
            else if (avail_w[2]) next_w = WPN_CAR;
            else                 next_w = WPN_WOODEN;
         end
         WPN_BASYS: begin
            cur_ok_w = avail_w[1];
            next_w   = avail_w[2] ? WPN_CAR : WPN_WOODEN;
         end
         WPN_CAR: begin
            cur_ok_w = avail_w[2];
            next_w   = WPN_WOODEN;
         end
         default: begin
            cur_ok_w = 1'b0;
            next_w   = WPN_WOODEN;
         end
      endcase
   end

   // Lock fallback has priority over a step request
   always_comb begin
      wtype_d = wtype_q;
      if (!cur_ok_w) begin
         wtype_d = WPN_WOODEN;
      end else if (wpn_next_i && enable_i) begin
         wtype_d = next_w;
      end
   end

   // Selected weapon register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) wtype_q <= WPN_WOODEN;
      else        wtype_q <= wtype_d;
   end

   assign weapon_type_o = wtype_q;

endmodule
`default_nettype wire

// File: rtl/attack_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : attack_ctrl
// Purpose  : Sequences CY's attack IDLE -> WINDUP -> ACTIVE -> COOLDOWN,
//            latches facing at acceptance, drives the attack state code and
//            owns the weapon selection. All outputs are registered.
// Revision : 1.0 - initial release
// ============================================================================
module attack_ctrl
   import attack_ctrl_pkg::*;
#(
   parameter int unsigned WINDUP_CYC   = 2_000_000,
   parameter int unsigned ACTIVE_CYC   = 10_000_000,
   parameter int unsigned COOLDOWN_CYC = 20_000_000,
   parameter int unsigned CNT_W        = 25
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] stage_i,
   input  logic       atk_req_i,
   input  logic [1:0] facing_i,
   input  logic       wpn_next_i,
   input  logic [2:0] unlocked_i,
   output logic [3:0] atk_state_o,
   output logic [2:0] weapon_type_o,
   output logic       hit_strobe_o,
   output logic       busy_o
);

   localparam logic [CNT_W-1:0] c_WINDUP_LAST   = CNT_W'(WINDUP_CYC - 1);
   localparam logic [CNT_W-1:0] c_ACTIVE_LAST   = CNT_W'(ACTIVE_CYC - 1);
   localparam logic [CNT_W-1:0] c_COOLDOWN_LAST = CNT_W'(COOLDOWN_CYC - 1);
   localparam logic [CNT_W-1:0] c_CNT_ONE       = CNT_W'(1);

   phase_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       dir_q, dir_d;
   logic [3:0]       atk_state_q, atk_state_d;
   logic             hit_q, hit_d;
   logic             busy_q, busy_d;
   logic             stage_act_w;

   assign stage_act_w = stage_is_active(stage_i);

   // State, phase counter and direction latch registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         dir_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dir_q   <= dir_d;
      end
   end

   // Next phase: counter restarts on every entry, stage drop aborts to IDLE
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + c_CNT_ONE;
      dir_d   = dir_q;
      if (!stage_act_w) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               cnt_d = '0;
               if (atk_req_i) begin
                  state_d = ST_WINDUP;
                  dir_d   = facing_i;
               end
            end
            ST_WINDUP: begin
               if (cnt_q == c_WINDUP_LAST) begin
                  state_d = ST_ACTIVE;
                  cnt_d   = '0;
               end
            end
            ST_ACTIVE: begin
               if (cnt_q == c_ACTIVE_LAST) begin
                  state_d = ST_COOLDOWN;
                  cnt_d   = '0;
               end
            end
            ST_COOLDOWN: begin
               if (cnt_q == c_COOLDOWN_LAST) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Output values for the coming cycle, derived from the next phase
   always_comb begin
      atk_state_d = ATK_NONE;
      if (state_d == ST_ACTIVE) atk_state_d = ATK_BACK + {2'b00, dir_d};
      hit_d  = (state_d == ST_ACTIVE) && (state_q != ST_ACTIVE);
      busy_d = (state_d != ST_IDLE);
   end

   // Registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         atk_state_q <= ATK_NONE;
         hit_q       <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         atk_state_q <= atk_state_d;
         hit_q       <= hit_d;
         busy_q      <= busy_d;
      end
   end

   weapon_cycler u_weapon_cycler (
      .clk           (clk),
      .rst_n         (rst_n),
      .unlocked_i    (unlocked_i),
      .wpn_next_i    (wpn_next_i),
      .enable_i      (state_q == ST_IDLE),
      .weapon_type_o (weapon_type_o)
   );

   assign atk_state_o  = atk_state_q;
   assign hit_strobe_o = hit_q;
   assign busy_o       = busy_q;

endmodule
`default_nettype wire
